// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, register numbers, bit positions
// and helpers that pack the architectural SR/Cause words.
package cp0_pkg;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE       = 0;
    localparam int SR_EXL      = 1;
    localparam int SR_IM_LO    = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO = 10;
    localparam int CAUSE_BD    = 31;

    function automatic logic [31:0] packSr(input logic [5:0] im,
                                           input logic exl,
                                           input logic ie);
        logic [31:0] w;
        w = '0;
        w[SR_IM_LO +: 6] = im;
        w[SR_EXL]        = exl;
        w[SR_IE]         = ie;
        return w;
    endfunction

    function automatic logic [31:0] packCause(input logic bd,
                                              input logic [5:0] ip,
                                              input logic [4:0] excCode);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD]            = bd;
        w[CAUSE_IP_LO +: 6]    = ip;
        w[CAUSE_EXC_LO +: 5]   = excCode;
        return w;
    endfunction

endpackage

// File: rtl/cp0.sv
// Coprocessor 0 for the pipelined MIPS core: exception/interrupt arbitration
// at the M stage, EPC/Cause/SR state, and the mtc0/mfc0/eret datapath.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID       = 32'h2024_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a_rd,
    input  logic [4:0]  a_wr,
    input  logic [31:0] din,
    input  logic        we,
    input  logic [31:0] pc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] handler_pc,
    output logic [31:0] epc_out,
    output logic [31:0] dout
);

    logic [5:0]  imQ, imD;
    logic        exlQ, exlD;
    logic        ieQ, ieD;
    logic        bdQ, bdD;
    logic [5:0]  ipQ, ipD;
    logic [4:0]  excCodeQ, excCodeD;
    logic [31:0] epcQ, epcD;

    logic intReq;
    logic excReq;

    // EXL masks both sources so a handler is never re-entered.
    assign intReq = (|(hw_int & imQ)) & ieQ & ~exlQ;
    assign excReq = (exc_code_in != EXC_INT) & ~exlQ;
    assign req    = intReq | excReq;

    assign handler_pc = HANDLER_PC;
    assign epc_out    = (we && (a_wr == CP0_EPC)) ? din : epcQ;

    always_comb begin
        dout = '0;
        case (a_rd)
            CP0_SR:    dout = packSr(imQ, exlQ, ieQ);
            CP0_CAUSE: dout = packCause(bdQ, ipQ, excCodeQ);
            CP0_EPC:   dout = epcQ;
            CP0_PRID:  dout = PRID;
            default:   dout = '0;
        endcase
    end

    // A taken request flushes the M instruction, so its mtc0/eret must not land.
    always_comb begin
        imD      = imQ;
        exlD     = exlQ;
        ieD      = ieQ;
        bdD      = bdQ;
        ipD      = hw_int;
        excCodeD = excCodeQ;
        epcD     = epcQ;
        if (req) begin
            exlD     = 1'b1;
            excCodeD = intReq ? EXC_INT : exc_code_in;
            bdD      = bd_in;
            epcD     = bd_in ? (pc - 32'd4) : pc;
        end else begin
            if (we) begin
                case (a_wr)
                    CP0_SR: begin
                        imD  = din[SR_IM_LO +: 6];
                        exlD = din[SR_EXL];
                        ieD  = din[SR_IE];
                    end
                    CP0_EPC: epcD = {din[31:2], 2'b00};
                    default: ;
                endcase
            end
            if (eret) begin
                exlD = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            imQ      <= '0;
            exlQ     <= 1'b0;
            ieQ      <= 1'b0;
            bdQ      <= 1'b0;
            ipQ      <= '0;
            excCodeQ <= '0;
            epcQ     <= '0;
        end else begin
            imQ      <= imD;
            exlQ     <= exlD;
            ieQ      <= ieD;
            bdQ      <= bdD;
            ipQ      <= ipD;
            excCodeQ <= excCodeD;
            epcQ     <= epcD;
        end
    end

endmodule

// File: tb/tb_cp0.sv
// Table-driven bench for cp0: each vector is driven for one cycle and the
// combinational outputs are compared before the following clock edge.
module tb_cp0;

    localparam logic [31:0] HPC  = 32'h0000_4180;
    localparam logic [31:0] PRID = 32'h2024_0007;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  a_rd, a_wr;
    logic [31:0] din, pc;
    logic        we, bd_in, eret;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        req;
    logic [31:0] handler_pc, epc_out, dout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  aRd;
        logic [4:0]  aWr;
        logic [31:0] din;
        logic        we;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        eret;
        logic        expReq;
        logic [31:0] expEpc;
        logic [31:0] expDout;
    } vec_t;

    vec_t vecs[$];

    cp0 #(.HANDLER_PC(HPC), .PRID(PRID)) dut (
        .clk(clk), .reset(reset), .a_rd(a_rd), .a_wr(a_wr), .din(din),
        .we(we), .pc(pc), .bd_in(bd_in), .exc_code_in(exc_code_in),
        .hw_int(hw_int), .eret(eret), .req(req), .handler_pc(handler_pc),
        .epc_out(epc_out), .dout(dout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] aRd, input logic [4:0] aWr,
                                input logic [31:0] d, input logic w,
                                input logic [31:0] p, input logic bd,
                                input logic [4:0] exc, input logic [5:0] hw,
                                input logic er, input logic eReq,
                                input logic [31:0] eEpc, input logic [31:0] eDout);
        vec_t v;
        v.aRd = aRd; v.aWr = aWr; v.din = d; v.we = w; v.pc = p; v.bd = bd;
        v.exc = exc; v.hw = hw; v.eret = er; v.expReq = eReq;
        v.expEpc = eEpc; v.expDout = eDout;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        a_rd = v.aRd; a_wr = v.aWr; din = v.din; we = v.we; pc = v.pc;
        bd_in = v.bd; exc_code_in = v.exc; hw_int = v.hw; eret = v.eret;
    endtask

    task automatic idleInputs();
        a_rd = 5'd0; a_wr = 5'd0; din = '0; we = 1'b0; pc = '0;
        bd_in = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0; eret = 1'b0;
    endtask

    initial begin
        // a_rd, a_wr, din, we, pc, bd, exc, hw, eret, req, epc_out, dout
        vecs.push_back(mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, PRID));
        vecs.push_back(mk(3,  0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(12, 12, 32'h401, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(12, 0, 0, 0, 32'h1000, 0, 0, 6'b1, 0, 1, 32'h0, 32'h401));
        vecs.push_back(mk(13, 0, 0, 0, 0, 0, 0, 6'b1, 0, 0, 32'h1000, 32'h400));
        vecs.push_back(mk(14, 0, 0, 0, 0, 0, 0, 6'b1, 0, 0, 32'h1000, 32'h1000));
        vecs.push_back(mk(12, 0, 0, 0, 0, 0, 4, 6'b1, 0, 0, 32'h1000, 32'h403));
        vecs.push_back(mk(12, 0, 0, 0, 0, 0, 0, 6'b1, 1, 0, 32'h1000, 32'h403));
        vecs.push_back(mk(12, 0, 0, 0, 32'h2000, 0, 0, 6'b1, 0, 1, 32'h1000, 32'h401));
        vecs.push_back(mk(14, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h2000, 32'h2000));
        vecs.push_back(mk(13, 12, 0, 1, 32'h3008, 1, 10, 0, 0, 1, 32'h2000, 32'h0));
        vecs.push_back(mk(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 32'h8000_0028));
        vecs.push_back(mk(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 32'h3004));
        vecs.push_back(mk(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 32'h403));
        vecs.push_back(mk(12, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h3004, 32'h403));
        vecs.push_back(mk(12, 0, 0, 0, 32'h4000, 0, 12, 6'b1, 0, 1, 32'h3004, 32'h401));
        vecs.push_back(mk(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4000, 32'h400));
        vecs.push_back(mk(14, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h4000, 32'h4000));
        vecs.push_back(mk(14, 14, 32'h3013, 1, 0, 0, 0, 0, 1, 0, 32'h3013, 32'h4000));
        vecs.push_back(mk(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3010, 32'h3010));
        vecs.push_back(mk(12, 0, 0, 0, 32'h0, 1, 5, 0, 0, 1, 32'h3010, 32'h401));
        vecs.push_back(mk(14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC));
        vecs.push_back(mk(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h8000_0014));
        vecs.push_back(mk(13, 13, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h8000_0014));
        vecs.push_back(mk(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h8000_0014));
        vecs.push_back(mk(12, 0, 0, 0, 0, 0, 0, 6'b10, 0, 0, 32'hFFFF_FFFC, 32'h401));
        vecs.push_back(mk(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h8000_0814));

        idleInputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rstReq", {31'd0, req}, 32'd0);
        checkOutput("handlerPc", handler_pc, HPC);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d.req", i), {31'd0, req}, {31'd0, vecs[i].expReq});
            checkOutput($sformatf("v%0d.epcOut", i), epc_out, vecs[i].expEpc);
            checkOutput($sformatf("v%0d.dout", i), dout, vecs[i].expDout);
        end

        // Reset wins over a simultaneous exception and mtc0.
        @(negedge clk);
        idleInputs();
        reset = 1'b1; exc_code_in = 5'd10; pc = 32'h5000;
        we = 1'b1; a_wr = 5'd14; din = 32'h7777_7770;
        @(negedge clk);
        idleInputs();
        reset = 1'b0;
        a_rd = 5'd14;
        #1;
        checkOutput("rstEpc", dout, 32'h0);
        checkOutput("rstEpcOut", epc_out, 32'h0);
        a_rd = 5'd12;
        #1;
        checkOutput("rstSr", dout, 32'h0);
        a_rd = 5'd13;
        #1;
        checkOutput("rstCause", dout, 32'h0);
        a_rd = 5'd15;
        #1;
        checkOutput("rstPrid", dout, PRID);

        // Interrupts stay masked until IE is enabled.
        hw_int = 6'b111111;
        #1;
        checkOutput("maskedIrq", {31'd0, req}, 32'd0);
        @(negedge clk);
        a_rd = 5'd13;
        #1;
        checkOutput("ipTracks", dout, 32'h0000_FC00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
